// File: rtl/if_id_stage.sv
// IF/ID pipeline register: aligns BRAM data with its fetch address, stalls on load-use
// hazards through a one-entry skid buffer, and squashes wrong-path words after a taken branch.
module if_id_stage #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] instruc_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              flush,
  input  logic              id_ex_mem_read,
  input  logic [4:0]        id_ex_rt,
  output logic              PC_write,
  output logic [DATA_W-1:0] instruc_out,
  output logic [ADDR_W-1:0] pc_plus_1_out,
  output logic              valid_out,
  output logic              id_ex_bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  typedef enum logic [1:0] {FILL, RUN, HOLD, SQUASH} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc;

  logic hazard;
  logic ld_fetch, ld_skid, ld_nop, cap_skid, cnt_stall, cnt_flush;

  assign hazard = valid_out & id_ex_mem_read & (id_ex_rt != 5'd0) &
                  ((id_ex_rt == instruc_out[25:21]) | (id_ex_rt == instruc_out[20:16]));

  always_comb begin
    state_next   = state;
    PC_write     = 1'b0;
    id_ex_bubble = 1'b0;
    ld_fetch     = 1'b0;
    ld_skid      = 1'b0;
    ld_nop       = 1'b0;
    cap_skid     = 1'b0;
    cnt_stall    = 1'b0;
    cnt_flush    = 1'b0;
    if (!enable) begin
      // Frozen, but the word on the BRAM bus must still be parked or it is lost.
      if (state == RUN) begin
        cap_skid   = 1'b1;
        state_next = HOLD;
      end
    end else if (flush) begin
      ld_nop     = 1'b1;
      PC_write   = 1'b1;
      cnt_flush  = 1'b1;
      state_next = SQUASH;
    end else begin
      case (state)
        FILL: begin
          ld_nop     = 1'b1;
          PC_write   = 1'b1;
          state_next = RUN;
        end
        RUN: begin
          if (hazard) begin
            cap_skid     = 1'b1;
            id_ex_bubble = 1'b1;
            cnt_stall    = 1'b1;
            state_next   = HOLD;
          end else begin
            ld_fetch = 1'b1;
            PC_write = 1'b1;
          end
        end
        HOLD: begin
          if (hazard) begin
            id_ex_bubble = 1'b1;
            cnt_stall    = 1'b1;
          end else begin
            // Drain: the BRAM re-presents the following word next cycle.
            ld_skid    = 1'b1;
            PC_write   = 1'b1;
            state_next = RUN;
          end
        end
        SQUASH: begin
          ld_nop     = 1'b1;
          PC_write   = 1'b1;
          state_next = RUN;
        end
        default: state_next = FILL;
      endcase
    end
    if (reset) begin
      PC_write     = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      pc_d          <= '0;
      skid_instr    <= '0;
      skid_pc       <= '0;
      instruc_out   <= '0;
      pc_plus_1_out <= '0;
      valid_out     <= 1'b0;
      stall_count   <= '0;
      flush_count   <= '0;
    end else begin
      state <= state_next;
      if (enable) pc_d <= pc_in;
      if (cap_skid) begin
        skid_instr <= instruc_in;
        skid_pc    <= pc_d;
      end
      if (ld_nop) begin
        instruc_out   <= '0;
        pc_plus_1_out <= '0;
        valid_out     <= 1'b0;
      end else if (ld_fetch) begin
        instruc_out   <= instruc_in;
        pc_plus_1_out <= pc_d + ADDR_ONE;
        valid_out     <= 1'b1;
      end else if (ld_skid) begin
        instruc_out   <= skid_instr;
        pc_plus_1_out <= skid_pc + ADDR_ONE;
        valid_out     <= 1'b1;
      end
      if (cnt_stall && (stall_count != '1)) stall_count <= stall_count + CNT_ONE;
      if (cnt_flush && (flush_count != '1)) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: models the fetch PC and a one-cycle-latency BRAM,
// plus a CNT_W=4 instance sharing the same stimulus for counter saturation.
module tb_if_id_stage;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset, enable, flush, id_ex_mem_read;
  logic [4:0]        id_ex_rt;
  logic [DATA_W-1:0] instruc_in;
  logic [ADDR_W-1:0] pc_in, target;

  logic              PC_write, valid_out, id_ex_bubble;
  logic [DATA_W-1:0] instruc_out;
  logic [ADDR_W-1:0] pc_plus_1_out;
  logic [CNT_W-1:0]  stall_count, flush_count;

  logic              s_PC_write, s_valid_out, s_id_ex_bubble;
  logic [DATA_W-1:0] s_instruc_out;
  logic [ADDR_W-1:0] s_pc_plus_1_out;
  logic [3:0]        s_stall_count, s_flush_count;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  if_id_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .enable(enable), .instruc_in(instruc_in), .pc_in(pc_in),
    .flush(flush), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .PC_write(PC_write), .instruc_out(instruc_out), .pc_plus_1_out(pc_plus_1_out),
    .valid_out(valid_out), .id_ex_bubble(id_ex_bubble),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  if_id_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(4)) dut_small (
    .clock(clock), .reset(reset), .enable(enable), .instruc_in(instruc_in), .pc_in(pc_in),
    .flush(flush), .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .PC_write(s_PC_write), .instruc_out(s_instruc_out), .pc_plus_1_out(s_pc_plus_1_out),
    .valid_out(s_valid_out), .id_ex_bubble(s_id_ex_bubble),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  // Memory image: rs = addr[4:0], rt = 20 on odd addresses and 0 on even ones.
  function automatic logic [31:0] word(input logic [9:0] a);
    return {6'h08, a[4:0], (a[0] ? 5'd20 : 5'd0), 6'd0, a};
  endfunction

  // Called at a negedge; returns at the next negedge after the fetch model has stepped.
  task automatic tick();
    logic          pw;
    logic [9:0]    old;
    #1 pw = PC_write;
    @(posedge clock);
    #1 old = pc_in;
    if (pw) pc_in = flush ? target : pc_in + 10'd1;
    instruc_in = word(old);
    @(negedge clock);
  endtask

  task automatic clear_hazard();
    id_ex_mem_read = 1'b0;
    id_ex_rt       = 5'd0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++; if (instruc_out !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instruc_out); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    total++; if (pc_plus_1_out !== 10'd0) begin bad++; $display("FAIL reset_pc1 got=%0d exp=0", pc_plus_1_out); end
    total++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin bad++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stall_count, flush_count); end
    total++; if (PC_write !== 1'b0 || id_ex_bubble !== 1'b0) begin bad++; $display("FAIL reset_comb got=%b%b exp=00", PC_write, id_ex_bubble); end
    reset = 1'b0;
    #1;
    total++; if (PC_write !== 1'b1) begin bad++; $display("FAIL fill_pc_write got=%b exp=1", PC_write); end
  endtask

  task automatic test_straight();
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL fill_bubble got=%b exp=0", valid_out); end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (instruc_out !== word(10'(k)) || valid_out !== 1'b1) begin bad++; $display("FAIL straight_instr k=%0d got=%h/%b exp=%h/1", k, instruc_out, valid_out, word(10'(k))); end
      total++; if (pc_plus_1_out !== 10'(k + 1)) begin bad++; $display("FAIL straight_pc1 k=%0d got=%0d exp=%0d", k, pc_plus_1_out, k + 1); end
      total++; if (PC_write !== 1'b1) begin bad++; $display("FAIL straight_pc_write k=%0d got=%b exp=1", k, PC_write); end
    end
  endtask

  task automatic test_hazard_rs();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd5;
    #1;
    total++; if (id_ex_bubble !== 1'b1 || PC_write !== 1'b0) begin bad++; $display("FAIL hz_rs_stall got=%b%b exp=10", id_ex_bubble, PC_write); end
    tick();
    clear_hazard();
    #1;
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL hz_rs_count got=%0d exp=1", stall_count); end
    total++; if (instruc_out !== word(10'd5) || PC_write !== 1'b1) begin bad++; $display("FAIL hz_rs_hold got=%h/%b exp=%h/1", instruc_out, PC_write, word(10'd5)); end
    tick();
    total++; if (instruc_out !== word(10'd6) || pc_plus_1_out !== 10'd7) begin bad++; $display("FAIL hz_rs_drain got=%h/%0d exp=%h/7", instruc_out, pc_plus_1_out, word(10'd6)); end
    tick();
    total++; if (instruc_out !== word(10'd7)) begin bad++; $display("FAIL hz_rs_next got=%h exp=%h", instruc_out, word(10'd7)); end
  endtask

  task automatic test_hazard_rt();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd20;
    #1;
    total++; if (id_ex_bubble !== 1'b1) begin bad++; $display("FAIL hz_rt_bubble got=%b exp=1", id_ex_bubble); end
    tick();
    #1;
    total++; if (id_ex_bubble !== 1'b1 || PC_write !== 1'b0 || instruc_out !== word(10'd7)) begin bad++; $display("FAIL hz_rt_hold got=%b%b/%h exp=10/%h", id_ex_bubble, PC_write, instruc_out, word(10'd7)); end
    tick();
    clear_hazard();
    total++; if (stall_count !== 16'd3) begin bad++; $display("FAIL hz_rt_count got=%0d exp=3", stall_count); end
    tick();
    total++; if (instruc_out !== word(10'd8) || pc_plus_1_out !== 10'd9) begin bad++; $display("FAIL hz_rt_drain got=%h/%0d exp=%h/9", instruc_out, pc_plus_1_out, word(10'd8)); end
    // word8 has rt field 0: a load to $0 must not stall.
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0;
    #1;
    total++; if (id_ex_bubble !== 1'b0 || PC_write !== 1'b1) begin bad++; $display("FAIL hz_zero got=%b%b exp=01", id_ex_bubble, PC_write); end
    tick();
    total++; if (instruc_out !== word(10'd9) || stall_count !== 16'd3) begin bad++; $display("FAIL hz_zero_next got=%h/%0d exp=%h/3", instruc_out, stall_count, word(10'd9)); end
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd9;
    #1;
    total++; if (id_ex_bubble !== 1'b0) begin bad++; $display("FAIL hz_noload got=%b exp=0", id_ex_bubble); end
    tick();
    clear_hazard();
    total++; if (instruc_out !== word(10'd10)) begin bad++; $display("FAIL hz_noload_next got=%h exp=%h", instruc_out, word(10'd10)); end
  endtask

  task automatic test_flush();
    flush = 1'b1; target = 10'd20;
    #1;
    total++; if (PC_write !== 1'b1) begin bad++; $display("FAIL flush_pc_write got=%b exp=1", PC_write); end
    tick();
    flush = 1'b0;
    total++; if (valid_out !== 1'b0 || flush_count !== 16'd1) begin bad++; $display("FAIL flush_b1 got=%b/%0d exp=0/1", valid_out, flush_count); end
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL flush_b2 got=%b exp=0", valid_out); end
    tick();
    total++; if (instruc_out !== word(10'd20) || pc_plus_1_out !== 10'd21 || valid_out !== 1'b1) begin bad++; $display("FAIL flush_target got=%h/%0d exp=%h/21", instruc_out, pc_plus_1_out, word(10'd20)); end
    tick();
    total++; if (instruc_out !== word(10'd21)) begin bad++; $display("FAIL flush_next got=%h exp=%h", instruc_out, word(10'd21)); end
  endtask

  task automatic test_back_to_back();
    flush = 1'b1; target = 10'd40;
    tick();
    target = 10'd60;
    tick();
    flush = 1'b0;
    total++; if (valid_out !== 1'b0 || flush_count !== 16'd3) begin bad++; $display("FAIL b2b_b1 got=%b/%0d exp=0/3", valid_out, flush_count); end
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_b2 got=%b exp=0", valid_out); end
    tick();
    total++; if (instruc_out !== word(10'd60) || pc_plus_1_out !== 10'd61) begin bad++; $display("FAIL b2b_target got=%h/%0d exp=%h/61", instruc_out, pc_plus_1_out, word(10'd60)); end
  endtask

  task automatic test_flush_hold();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd28;
    tick();
    flush = 1'b1; target = 10'd100;
    #1;
    total++; if (id_ex_bubble !== 1'b0 || PC_write !== 1'b1) begin bad++; $display("FAIL fh_prio got=%b%b exp=01", id_ex_bubble, PC_write); end
    tick();
    flush = 1'b0;
    clear_hazard();
    total++; if (valid_out !== 1'b0 || flush_count !== 16'd4 || stall_count !== 16'd4) begin bad++; $display("FAIL fh_b1 got=%b/%0d/%0d exp=0/4/4", valid_out, flush_count, stall_count); end
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL fh_b2 got=%b exp=0", valid_out); end
    tick();
    total++; if (instruc_out !== word(10'd100) || pc_plus_1_out !== 10'd101) begin bad++; $display("FAIL fh_target got=%h/%0d exp=%h/101", instruc_out, pc_plus_1_out, word(10'd100)); end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    flush = 1'b1; target = 10'd300;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (PC_write !== 1'b0 || id_ex_bubble !== 1'b0) begin bad++; $display("FAIL en_comb i=%0d got=%b%b exp=00", i, PC_write, id_ex_bubble); end
      tick();
      total++; if (instruc_out !== word(10'd100) || valid_out !== 1'b1 || pc_plus_1_out !== 10'd101 || flush_count !== 16'd4) begin bad++; $display("FAIL en_frozen i=%0d got=%h/%b/%0d/%0d exp=%h/1/101/4", i, instruc_out, valid_out, pc_plus_1_out, flush_count, word(10'd100)); end
    end
    flush = 1'b0;
    enable = 1'b1;
    tick();
    total++; if (instruc_out !== word(10'd101) || pc_plus_1_out !== 10'd102) begin bad++; $display("FAIL en_resume got=%h/%0d exp=%h/102", instruc_out, pc_plus_1_out, word(10'd101)); end
    tick();
    total++; if (instruc_out !== word(10'd102)) begin bad++; $display("FAIL en_resume2 got=%h exp=%h", instruc_out, word(10'd102)); end
  endtask

  task automatic test_enable_hazard();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd6;
    enable = 1'b0;
    #1;
    total++; if (id_ex_bubble !== 1'b0 || PC_write !== 1'b0) begin bad++; $display("FAIL enhz_off got=%b%b exp=00", id_ex_bubble, PC_write); end
    tick();
    total++; if (stall_count !== 16'd4) begin bad++; $display("FAIL enhz_count_off got=%0d exp=4", stall_count); end
    enable = 1'b1;
    #1;
    total++; if (id_ex_bubble !== 1'b1 || PC_write !== 1'b0) begin bad++; $display("FAIL enhz_on got=%b%b exp=10", id_ex_bubble, PC_write); end
    tick();
    clear_hazard();
    total++; if (stall_count !== 16'd5) begin bad++; $display("FAIL enhz_count_on got=%0d exp=5", stall_count); end
    tick();
    total++; if (instruc_out !== word(10'd103)) begin bad++; $display("FAIL enhz_drain got=%h exp=%h", instruc_out, word(10'd103)); end
    tick();
    total++; if (instruc_out !== word(10'd104)) begin bad++; $display("FAIL enhz_next got=%h exp=%h", instruc_out, word(10'd104)); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; target = 10'd1022;
    tick();
    flush = 1'b0;
    repeat (2) tick();
    total++; if (instruc_out !== word(10'd1022) || pc_plus_1_out !== 10'd1023) begin bad++; $display("FAIL wrap_1022 got=%h/%0d exp=%h/1023", instruc_out, pc_plus_1_out, word(10'd1022)); end
    tick();
    total++; if (instruc_out !== word(10'd1023) || pc_plus_1_out !== 10'd0) begin bad++; $display("FAIL wrap_1023 got=%h/%0d exp=%h/0", instruc_out, pc_plus_1_out, word(10'd1023)); end
    tick();
    total++; if (instruc_out !== word(10'd0) || pc_plus_1_out !== 10'd1) begin bad++; $display("FAIL wrap_0 got=%h/%0d exp=%h/1", instruc_out, pc_plus_1_out, word(10'd0)); end
    tick();
    total++; if (instruc_out !== word(10'd1) || flush_count !== 16'd5) begin bad++; $display("FAIL wrap_1 got=%h/%0d exp=%h/5", instruc_out, flush_count, word(10'd1)); end
  endtask

  task automatic test_reset_hold();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd1;
    repeat (2) tick();
    total++; if (stall_count !== 16'd7 || instruc_out !== word(10'd1)) begin bad++; $display("FAIL rh_pre got=%0d/%h exp=7/%h", stall_count, instruc_out, word(10'd1)); end
    #2 reset = 1'b1;
    #1;
    total++; if (instruc_out !== 32'd0 || valid_out !== 1'b0 || pc_plus_1_out !== 10'd0) begin bad++; $display("FAIL rh_async got=%h/%b/%0d exp=0/0/0", instruc_out, valid_out, pc_plus_1_out); end
    total++; if (stall_count !== 16'd0 || flush_count !== 16'd0 || PC_write !== 1'b0 || id_ex_bubble !== 1'b0) begin bad++; $display("FAIL rh_async2 got=%0d/%0d/%b%b exp=0/0/00", stall_count, flush_count, PC_write, id_ex_bubble); end
    clear_hazard();
    pc_in = '0;
    instruc_in = '0;
    @(negedge clock);
    reset = 1'b0;
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rh_fill got=%b exp=0", valid_out); end
    tick();
    total++; if (instruc_out !== word(10'd0) || pc_plus_1_out !== 10'd1) begin bad++; $display("FAIL rh_first got=%h/%0d exp=%h/1", instruc_out, pc_plus_1_out, word(10'd0)); end
  endtask

  task automatic test_saturate();
    flush = 1'b1; target = 10'd200;
    repeat (15) tick();
    total++; if (s_flush_count !== 4'd15 || flush_count !== 16'd15) begin bad++; $display("FAIL sat_flush15 got=%0d/%0d exp=15/15", s_flush_count, flush_count); end
    repeat (3) tick();
    total++; if (s_flush_count !== 4'd15 || flush_count !== 16'd18) begin bad++; $display("FAIL sat_flush18 got=%0d/%0d exp=15/18", s_flush_count, flush_count); end
    flush = 1'b0;
    repeat (2) tick();
    total++; if (instruc_out !== word(10'd200)) begin bad++; $display("FAIL sat_target got=%h exp=%h", instruc_out, word(10'd200)); end
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd8;
    repeat (15) tick();
    total++; if (s_stall_count !== 4'd15 || stall_count !== 16'd15) begin bad++; $display("FAIL sat_stall15 got=%0d/%0d exp=15/15", s_stall_count, stall_count); end
    repeat (2) tick();
    total++; if (s_stall_count !== 4'd15 || stall_count !== 16'd17) begin bad++; $display("FAIL sat_stall17 got=%0d/%0d exp=15/17", s_stall_count, stall_count); end
    clear_hazard();
    tick();
    total++; if (instruc_out !== word(10'd201)) begin bad++; $display("FAIL sat_drain got=%h exp=%h", instruc_out, word(10'd201)); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    pc_in = '0; instruc_in = '0; target = '0;
    test_reset();
    test_straight();
    test_hazard_rs();
    test_hazard_rt();
    test_flush();
    test_back_to_back();
    test_flush_hold();
    test_enable();
    test_enable_hazard();
    test_wrap();
    test_reset_hold();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline stage directly downstream of instruction_fetch.
- Pairs each synchronous-BRAM instruction word with its fetch address, which requires a one-cycle alignment because memory data arrives one cycle after the address.
- Registers the pair into the ID stage, detects load-use hazards, and drives PC_write back to fetch.
- Handles branch/jump flush with wrong-path squash, and provides a skid buffer so no fetched word is lost on stall or debug hold.

Parameters:
ADDR_W, 10, PC/instruction-memory address width
DATA_W, 32, instruction width
CNT_W, 16, width of stall/flush event counters

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  global step enable (UART debug); 0 = freeze stage
instruc_in  input  DATA_W  BRAM output (instruc of instruction_fetch)
pc_in  input  ADDR_W  PC_current of instruction_fetch
flush  input  1  branch/jump taken in ID this cycle (same cycle PC_sel/jump_sel asserted)
id_ex_mem_read  input  1  instruction in EX is a load
id_ex_rt  input  5  load destination register in EX
PC_write  output  1  PC update enable to instruction_fetch (combinational)
instruc_out  output  DATA_W  ID-stage instruction
pc_plus_1_out  output  ADDR_W  address of instruc_out + 1
valid_out  output  1  instruc_out is a real instruction
id_ex_bubble  output  1  force NOP into ID/EX this cycle (combinational)
stall_count  output  CNT_W  saturating count of hazard-stall cycles
flush_count  output  CNT_W  saturating count of accepted flushes

Behaviour:
- Reset (async, immediate):
  - instruc_out=0, pc_plus_1_out=0, valid_out=0, counters=0, skid empty.
  - Internal pc_d=0, state=FILL.
  - PC_write=0 and id_ex_bubble=0 while reset is high.
- Alignment:
  - pc_d <= pc_in every cycle with enable=1.
  - instruc_in in cycle n is the word at pc_d.
  - pc_plus_1_out = captured pc_d + 1, mod 2^ADDR_W (1023 -> 0).
- hazard = valid_out & id_ex_mem_read & (id_ex_rt!=0) & (id_ex_rt==instruc_out[25:21] | id_ex_rt==instruc_out[20:16]).
- hold = hazard | ~enable.
- Priority: reset > ~enable > flush > hazard > normal.
- States:
  - FILL (first cycle after reset): BRAM data invalid. IF/ID loads NOP (valid_out=0). PC_write=enable. Next state RUN when enable=1.
  - RUN, no hold:
    - IF/ID <= {instruc_in, pc_d+1}, valid_out=1, PC_write=1.
  - RUN with hold:
    - Skid <= {instruc_in, pc_d}; IF/ID holds; PC_write=0; go to HOLD.
    - id_ex_bubble = hazard & enable.
  - HOLD, hold still true: everything holds, PC_write=0, id_ex_bubble = hazard & enable.
  - HOLD, hold false (drain):
    - IF/ID <= skid content, valid_out=1, skid emptied, PC_write=1.
    - instruc_in this cycle is ignored; the same word is re-presented next cycle.
    - Next state RUN.
- SQUASH flush:
  - With enable=1 in any of FILL/RUN/HOLD: IF/ID <= NOP, valid_out=0, skid discarded, PC_write=1, flush_count++.
  - Next state SQUASH.
  - In SQUASH: instruc_in is a wrong-path word and is discarded. IF/ID <= NOP, valid_out=0. Next state RUN.
  - A flush during SQUASH restarts SQUASH (counted).
  - Net effect: a taken branch/jump costs exactly 2 bubbles.
- enable=0:
  - All registers hold, except the skid capture on a RUN->HOLD entry.
  - PC_write=0, id_ex_bubble=0, counters hold, flush ignored.
- Counters:
  - stall_count increments once per cycle with hazard & enable.
  - Both counters saturate at 2^CNT_W-1.
- Reset mid-stall/squash: returns to FILL; skid contents lost.

Test Plan:
- Reset, then straight-line code at words 0..5 with enable=1 -> one FILL bubble; valid_out rises on cycle 2; instruc_out follows word0..word5; pc_plus_1_out = 1..6; PC_write constantly 1.
- lw $2 in EX (id_ex_mem_read=1, id_ex_rt=2) with ID instr rs=2 -> id_ex_bubble=1 and PC_write=0 for 1 cycle; stall_count=1; next ID instruction follows without loss or duplication. Repeat with id_ex_rt=0 -> no stall.
- flush=1 while ID holds word at addr 4, target 20 -> two cycles valid_out=0; third cycle instruc_out=word20, pc_plus_1_out=21; flush_count=1.
- enable=0 for 3 cycles mid-stream -> outputs frozen, PC_write=0; on resume the sequence continues with no missing or duplicated word. Also toggle enable during an active hazard.
- Fetch wrap: pc_in 1022,1023,0 -> pc_plus_1_out 1023,0,1.
- Assert reset while in HOLD with skid full -> outputs zero immediately (asynchronous); FILL bubble follows release; counters saturate when preloaded near max (CNT_W=4 variant: 15 stays 15).
